// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-channel RAM port arbiter, data priority with instruction starvation guard
//
// Shares the single RAM port between the instruction and data request channels
// that the cache block drives. Data wins contention, but only MAX_DSTREAK times
// in a row while an instruction request is waiting. After that, the instruction
// channel is served.
//
// Each granted access latches its address, write data and op type. These latched
// values drive the RAM until ram_ready pulses. Every access returns to IDLE for
// one cycle before the next grant. This lets a requester that saw its wait drop
// withdraw its request before it can be granted a second time.
//
// Optional build macro: ARB_STATS_EN adds saturating grant/stall counters and
// the stat_* ports.
//
// Parameters:
//   ADDR_W       address width
//   DATA_W       data word width
//   MAX_DSTREAK  consecutive data grants allowed while an instruction waits (>=1)
//   STAT_W       statistics counter width (ARB_STATS_EN only)
//
// Ports:
//   CLK, nRST                  clock (rising edge), synchronous active-low reset
//   iREN, iaddr                instruction read request and address
//   dREN, dWEN, daddr, dstore  data read/write request, address and write value
//   iwait, dwait               low only in the cycle the channel's access completes
//   iload, dload               read data, valid while the matching wait is low
//   ram_ren, ram_wen           RAM strobes, held for the whole access
//   ram_addr, ram_store        latched RAM address and write data
//   ram_load, ram_ready        RAM read data and one-cycle completion pulse
//   stat_igrant, stat_dgrant   grant counters (ARB_STATS_EN only)
//   stat_stall                 cycles with a pending request still waiting (ARB_STATS_EN only)

module mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_DSTREAK = 4,
    parameter int STAT_W      = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              iwait,
    output logic              dwait,
    output logic [DATA_W-1:0] iload,
    output logic [DATA_W-1:0] dload,
    output logic              ram_ren,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_store,
    input  logic [DATA_W-1:0] ram_load,
    input  logic              ram_ready
`ifdef ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_igrant,
    output logic [STAT_W-1:0] stat_dgrant,
    output logic [STAT_W-1:0] stat_stall
`endif
);

    // The streak counter must be able to hold MAX_DSTREAK itself.
    localparam int SK_W = $clog2(MAX_DSTREAK + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2
    } state_t;

    state_t          state;
    logic [SK_W-1:0] streak;

    logic i_pend;
    logic d_pend;
    logic streak_full;
    logic grant_d;
    logic grant_i;

    assign i_pend      = iREN;
    assign d_pend      = dREN | dWEN;
    assign streak_full = (streak == SK_W'(MAX_DSTREAK));

    // Data wins contention until the streak limit is reached.
    // Either channel wins when it is the only one asking.
    assign grant_d = (state == IDLE) && d_pend && (!i_pend || !streak_full);
    assign grant_i = (state == IDLE) && i_pend && !grant_d;

    // A cycle with reset asserted never releases a wait.
    // An abandoned access therefore cannot look like a completed one.
    assign iwait = !(nRST && (state == IACC) && ram_ready);
    assign dwait = !(nRST && (state == DACC) && ram_ready);

    // Read data is a straight passthrough.
    // It is only meaningful while the matching wait is low.
    assign iload = ram_load;
    assign dload = ram_load;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state     <= IDLE;
            ram_ren   <= 1'b0;
            ram_wen   <= 1'b0;
            ram_addr  <= '0;
            ram_store <= '0;
            streak    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state     <= DACC;
                        // A simultaneous read and write request is treated as a write.
                        ram_wen   <= dWEN;
                        ram_ren   <= !dWEN;
                        ram_addr  <= daddr;
                        ram_store <= dstore;
                        // Only data grants that jump ahead of a waiting fetch count
                        // toward the streak.
                        streak    <= i_pend ? streak + SK_W'(1) : '0;
                    end else if (grant_i) begin
                        state    <= IACC;
                        ram_ren  <= 1'b1;
                        ram_wen  <= 1'b0;
                        ram_addr <= iaddr;
                        streak   <= '0;
                    end
                end
                IACC, DACC: begin
                    // Requester inputs are ignored here.
                    // Only the RAM can end the access.
                    if (ram_ready) begin
                        state   <= IDLE;
                        ram_ren <= 1'b0;
                        ram_wen <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ram_ren <= 1'b0;
                    ram_wen <= 1'b0;
                end
            endcase
        end
    end

`ifdef ARB_STATS_EN
    logic stall_now;

    // A stall cycle is one where some channel is asking and has not been released.
    assign stall_now = (i_pend && iwait) || (d_pend && dwait);

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            stat_igrant <= '0;
            stat_dgrant <= '0;
            stat_stall  <= '0;
        end else begin
            if (grant_i && (stat_igrant != '1)) begin
                stat_igrant <= stat_igrant + STAT_W'(1);
            end
            if (grant_d && (stat_dgrant != '1)) begin
                stat_dgrant <= stat_dgrant + STAT_W'(1);
            end
            if (stall_now && (stat_stall != '1)) begin
                stat_stall <= stat_stall + STAT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with a transaction-level reference model

module tb_mem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXD = 4;
    localparam int SW   = 16;

    logic          CLK = 1'b0;
    logic          nRST;
    logic          iREN;
    logic [AW-1:0] iaddr;
    logic          dREN;
    logic          dWEN;
    logic [AW-1:0] daddr;
    logic [DW-1:0] dstore;
    logic          iwait;
    logic          dwait;
    logic [DW-1:0] iload;
    logic [DW-1:0] dload;
    logic          ram_ren;
    logic          ram_wen;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_store;
    logic [DW-1:0] ram_load;
    logic          ram_ready;
`ifdef ARB_STATS_EN
    logic [SW-1:0] stat_igrant;
    logic [SW-1:0] stat_dgrant;
    logic [SW-1:0] stat_stall;
`endif

    mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MAX_DSTREAK(MAXD), .STAT_W(SW)
    ) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
        .ram_store(ram_store), .ram_load(ram_load), .ram_ready(ram_ready)
`ifdef ARB_STATS_EN
        , .stat_igrant(stat_igrant), .stat_dgrant(stat_dgrant), .stat_stall(stat_stall)
`endif
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: who owns the RAM port, and what that access looks like.
    // owner: 0 = nobody, 1 = instruction, 2 = data.
    int            m_owner  = 0;
    bit            m_wr     = 1'b0;
    logic [AW-1:0] m_addr   = '0;
    logic [DW-1:0] m_store  = '0;
    int            m_streak = 0;
    bit            last_icomp;
    bit            last_dcomp;
`ifdef ARB_STATS_EN
    int s_ig = 0, s_dg = 0, s_st = 0;
    localparam int SMAX = (1 << SW) - 1;
`endif

    // One clock: compare outputs mid-cycle, advance the model across the edge,
    // then let the requesters withdraw any request that has just completed.
    task automatic cycle();
        bit exp_iw, exp_dw, ip, dp;
        @(negedge CLK);
        exp_iw = !(nRST && m_owner == 1 && ram_ready);
        exp_dw = !(nRST && m_owner == 2 && ram_ready);
        check("iwait", iwait, exp_iw);
        check("dwait", dwait, exp_dw);
        check("ram_ren", ram_ren, (m_owner != 0) && !m_wr);
        check("ram_wen", ram_wen, (m_owner != 0) && m_wr);
        if (m_owner != 0) check("ram_addr", ram_addr, m_addr);
        if (m_owner == 2 && m_wr) check("ram_store", ram_store, m_store);
        if (!exp_iw) check("iload", iload, ram_load);
        if (!exp_dw && !m_wr) check("dload", dload, ram_load);
`ifdef ARB_STATS_EN
        check("stat_igrant", stat_igrant, s_ig);
        check("stat_dgrant", stat_dgrant, s_dg);
        check("stat_stall", stat_stall, s_st);
`endif
        last_icomp = !exp_iw;
        last_dcomp = !exp_dw;
        ip = iREN;
        dp = dREN || dWEN;
        if (!nRST) begin
            m_owner = 0; m_addr = '0; m_store = '0; m_streak = 0; m_wr = 1'b0;
`ifdef ARB_STATS_EN
            s_ig = 0; s_dg = 0; s_st = 0;
`endif
        end else begin
`ifdef ARB_STATS_EN
            if (((ip && exp_iw) || (dp && exp_dw)) && s_st < SMAX) s_st++;
`endif
            if (m_owner != 0) begin
                if (ram_ready) m_owner = 0;
            end else if (dp && (!ip || m_streak < MAXD)) begin
                m_owner = 2; m_wr = dWEN; m_addr = daddr; m_store = dstore;
                m_streak = ip ? m_streak + 1 : 0;
`ifdef ARB_STATS_EN
                if (s_dg < SMAX) s_dg++;
`endif
            end else if (ip) begin
                m_owner = 1; m_wr = 1'b0; m_addr = iaddr; m_streak = 0;
`ifdef ARB_STATS_EN
                if (s_ig < SMAX) s_ig++;
`endif
            end
        end
        @(posedge CLK);
        #1;
        if (last_icomp) iREN = 1'b0;
        if (last_dcomp) begin dREN = 1'b0; dWEN = 1'b0; end
    endtask

    int nd;
    bit got_i;

    initial begin
        nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0; ram_load = '0; ram_ready = 1'b0;

        // Reset held for two cycles.
        cycle(); cycle();
        check("rst_ram_ren", ram_ren, 0);
        check("rst_ram_wen", ram_wen, 0);
        check("rst_iwait", iwait, 1);
        check("rst_dwait", dwait, 1);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_store", ram_store, 0);
        nRST = 1'b1;

        // Single fetch, RAM ready three cycles after the grant.
        iREN = 1'b1; iaddr = 32'h40; ram_load = 32'h1234_5678;
        cycle();
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("fetch_ren", ram_ren, 1);
            check("fetch_addr", ram_addr, 32'h40);
        end
        ram_ready = 1'b1;
        cycle();
        check("fetch_done", last_icomp, 1);
        ram_ready = 1'b0;
        cycle();
        check("fetch_idle_ren", ram_ren, 0);

        // Simultaneous requests: data first, instruction after the IDLE bubble.
        iREN = 1'b1; iaddr = 32'h80; dREN = 1'b1; daddr = 32'h200;
        cycle();
        check("simul_d_addr", ram_addr, 32'h200);
        check("simul_d_ren", ram_ren, 1);
        ram_ready = 1'b1; ram_load = 32'hA5A5_0001;
        cycle();
        check("simul_d_done", last_dcomp, 1);
        ram_ready = 1'b0;
        cycle();
        check("simul_i_addr", ram_addr, 32'h80);
        check("simul_i_ren", ram_ren, 1);
        ram_ready = 1'b1;
        cycle();
        ram_ready = 1'b0;
        cycle();

        // Starvation guard: data re-requested after every completion.
        iREN = 1'b1; iaddr = 32'h300; dWEN = 1'b1; daddr = 32'h400; dstore = 32'h77;
        ram_ready = 1'b1; nd = 0; got_i = 1'b0;
        for (int k = 0; k < 40 && !got_i; k++) begin
            cycle();
            if (last_dcomp) nd++;
            if (last_icomp) got_i = 1'b1;
            else dWEN = 1'b1;
        end
        check("starve_i_served", got_i, 1);
        check("starve_dgrants", nd, MAXD);
        ram_ready = 1'b0; dWEN = 1'b0;
        cycle();

        // Write latch: request changes mid-access must not leak to the RAM.
        dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEAD_BEEF;
        cycle();
        daddr = 32'h5555; dstore = 32'h0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("latch_addr", ram_addr, 32'h100);
            check("latch_wen", ram_wen, 1);
            check("latch_store", ram_store, 32'hDEAD_BEEF);
        end
        ram_ready = 1'b1;
        cycle();
        ram_ready = 1'b0;
        cycle();

        // Reset in the middle of a data write.
        dWEN = 1'b1; daddr = 32'h180;
        cycle();
        check("midrst_wen_before", ram_wen, 1);
        nRST = 1'b0; dWEN = 1'b0;
        cycle();
        nRST = 1'b1;
        check("midrst_wen", ram_wen, 0);
        check("midrst_dwait", dwait, 1);
`ifdef ARB_STATS_EN
        check("midrst_stat_ig", stat_igrant, 0);
        check("midrst_stat_dg", stat_dgrant, 0);
        check("midrst_stat_st", stat_stall, 0);
`endif
        ram_ready = 1'b1;
        cycle();
        ram_ready = 1'b0;

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            if (!iREN && ($urandom % 4 == 0)) begin
                iREN = 1'b1; iaddr = $urandom;
            end
            if (!(dREN || dWEN) && ($urandom % 3 == 0)) begin
                case ($urandom % 3)
                    0: begin dREN = 1'b1; dWEN = 1'b0; end
                    1: begin dREN = 1'b0; dWEN = 1'b1; end
                    default: begin dREN = 1'b1; dWEN = 1'b1; end
                endcase
                daddr = $urandom; dstore = $urandom;
            end
            if ($urandom % 8 == 0) daddr = $urandom;
            if ($urandom % 8 == 0) iaddr = $urandom;
            ram_ready = ($urandom % 3 == 0);
            ram_load  = $urandom;
            nRST      = ($urandom % 300 != 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
